act_packer: RTL and testbench
=============================

ACT_PACKER -- requirements
Module: act_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of one 2's-complement activation element.
REQ-002 Parameter PACK_NUM, default 4; elements per packed output word, >=2.
REQ-003 Parameter CNT_WIDTH, default $clog2(PACK_NUM+1); width of o_count.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_en  input  1  block enable; input side ignored when low.
REQ-007 i_valid  input  1  element valid from the upstream activation stage (no backpressure).
REQ-008 i_data_bus  input  DATA_WIDTH  activation element.
REQ-009 i_last  input  1  close current word after this cycle (packet end / flush).
REQ-010 i_clr_ovf  input  1  clears o_overflow.
REQ-011 o_valid  output  1  packed word valid.
REQ-012 o_ready  input  1  downstream accepts word when o_valid & o_ready.
REQ-013 o_data_bus  output  DATA_WIDTH*PACK_NUM  packed word, element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 o_count  output  CNT_WIDTH  number of valid elements in o_data_bus (1..PACK_NUM).
REQ-015 o_last  output  1  word was closed by i_last.
REQ-016 o_overflow  output  1  sticky: an element was dropped.

Function
REQ-017 Two storage stages: pack register (filling, count 0..PACK_NUM, flag full) and output register (presenting, drives o_* ports).
REQ-018 Accepted element (i_en & i_valid, pack not full) written to lane = current count; first element after close lands in lane 0.
REQ-019 Data passes bit-exact, no arithmetic; unused lanes of a partial word zero.
REQ-020 Word closes when accepted element makes count == PACK_NUM, or on i_en & i_last with count (including this cycle's element) > 0; i_last with empty pack and no element ignored.
REQ-021 Closed word moves to output register on the closing edge if output register empty or drained same cycle (o_valid & o_ready); o_valid high the cycle after closing edge (latency 1).
REQ-022 Otherwise closed word held in pack register (full); moves to output register on the edge the output is drained.
REQ-023 Input arriving while pack full and output not drained that cycle: dropped, o_overflow set next cycle.
REQ-024 Input arriving while pack full and output drained same cycle: held word transfers, element accepted into lane 0 of fresh pack.
REQ-025 o_valid stays high, o_data_bus/o_count/o_last stable, until handshake; drain with no new word clears o_valid next cycle.
REQ-026 Drain and new close on same edge: new word loaded, o_valid remains high (back-to-back, full throughput).
REQ-027 i_en low: i_valid/i_last ignored; output handshake and held-word transfer continue.
REQ-028 i_clr_ovf clears o_overflow; simultaneous new drop wins (stays set).

Reset
REQ-029 On rst high asynchronously: pack count 0, full 0, all data registers 0, o_valid 0, o_count 0, o_last 0, o_overflow 0.
REQ-030 Reset mid-word discards partial and held words; no output after release until a new word closes.

Structure
REQ-031 Package act_pkg holds DATA_WIDTH and PACK_NUM defaults and the count-width constant shared with the activation stages.
REQ-032 One sub-module act_out_slice: the output register with valid/ready hold logic, instantiated once.

Verification
REQ-033 PACK_NUM=4, 4 consecutive elements 0x0001..0x0004, o_ready=1 -> next cycle o_valid=1, o_data_bus=0x0004_0003_0002_0001, o_count=4, o_last=0.
REQ-034 Elements 0x00AA,0x00BB then i_last with second -> o_data_bus=0x0000_0000_00BB_00AA, o_count=2, o_last=1.
REQ-035 o_ready=0, stream 9 elements -> words 1 and 2 held, 9th dropped, o_overflow=1; release o_ready -> words 1,2 delivered in order.
REQ-036 Continuous 8 elements with o_ready=1 -> two words on consecutive-close cycles, o_valid never gaps between them.
REQ-037 rst asserted after 2 elements, released, 4 new elements -> only word from new elements appears, lanes 0..3 correct.
REQ-038 i_en=0 with i_valid=1 for 4 cycles -> no word, o_overflow=0; i_clr_ovf clears a previously set o_overflow.

Source files
------------

// File: rtl/act_pkg.sv
// Shared activation-path constants: element width, pack factor and count width.
package act_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefPackNum   = 4;
  // Width needed to hold an element count of 0..DefPackNum.
  localparam int unsigned DefCntWidth  = $clog2(DefPackNum + 1);

endpackage

// File: rtl/act_out_slice.sv
// Output register of the packer: holds one packed word until the downstream handshake.
module act_out_slice
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned PACK_NUM   = DefPackNum,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_i,
  input  logic [DATA_WIDTH*PACK_NUM-1:0]   data_i,
  input  logic [CNT_WIDTH-1:0]             count_i,
  input  logic                             last_i,
  input  logic                             ready_i,
  output logic                             valid_o,
  output logic [DATA_WIDTH*PACK_NUM-1:0]   data_o,
  output logic [CNT_WIDTH-1:0]             count_o,
  output logic                             last_o
);

  logic                           valid_q;
  logic [DATA_WIDTH*PACK_NUM-1:0] data_q;
  logic [CNT_WIDTH-1:0]           count_q;
  logic                           last_q;

  // Load a new word (wins over drain so back-to-back words keep valid high), else clear on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/act_packer.sv
// Packs a stream of activation elements into PACK_NUM-wide words with a one-word skid
// (the pack register) in front of the output register.
module act_packer
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned PACK_NUM   = DefPackNum,
  parameter int unsigned CNT_WIDTH  = $clog2(PACK_NUM + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic                             i_valid,
  input  logic [DATA_WIDTH-1:0]            i_data_bus,
  input  logic                             i_last,
  input  logic                             i_clr_ovf,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [DATA_WIDTH*PACK_NUM-1:0]   o_data_bus,
  output logic [CNT_WIDTH-1:0]             o_count,
  output logic                             o_last,
  output logic                             o_overflow
);

  typedef logic [PACK_NUM-1:0][DATA_WIDTH-1:0] pack_t;

  pack_t                pack_data_q, pack_data_d;
  logic [CNT_WIDTH-1:0] pack_cnt_q, pack_cnt_d;
  logic                 pack_full_q, pack_full_d;
  logic                 pack_last_q, pack_last_d;
  logic                 ovf_q, ovf_d;

  logic                 out_free;
  logic                 in_fire;
  logic                 accept;
  logic                 drop;
  logic                 close;
  logic                 load;
  pack_t                load_data;
  logic [CNT_WIDTH-1:0] load_cnt;
  logic                 load_last;

  // Next-state of the pack register and the word handed to the output slice.
  always_comb begin
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    pack_full_d = pack_full_q;
    pack_last_d = pack_last_q;
    load        = 1'b0;
    load_data   = '0;
    load_cnt    = '0;
    load_last   = 1'b0;
    accept      = 1'b0;
    drop        = 1'b0;
    close       = 1'b0;
    out_free    = !o_valid || o_ready;
    in_fire     = i_en && i_valid;

    // A held word moves out first, freeing the pack for this cycle's element.
    if (pack_full_q && out_free) begin
      load        = 1'b1;
      load_data   = pack_data_q;
      load_cnt    = pack_cnt_q;
      load_last   = pack_last_q;
      pack_data_d = '0;
      pack_cnt_d  = '0;
      pack_full_d = 1'b0;
      pack_last_d = 1'b0;
    end

    if (in_fire) begin
      if (pack_full_d) begin
        drop = 1'b1;
      end else begin
        accept = 1'b1;
        for (int unsigned k = 0; k < PACK_NUM; k++) begin
          if (CNT_WIDTH'(k) == pack_cnt_d) begin
            pack_data_d[k] = i_data_bus;
          end
        end
        pack_cnt_d = pack_cnt_d + CNT_WIDTH'(1);
      end
    end

    close = !pack_full_d &&
            ((accept && (pack_cnt_d == CNT_WIDTH'(PACK_NUM))) ||
             (i_en && i_last && (pack_cnt_d != '0)));

    if (close) begin
      if (!load && out_free) begin
        load        = 1'b1;
        load_data   = pack_data_d;
        load_cnt    = pack_cnt_d;
        load_last   = i_en && i_last;
        pack_data_d = '0;
        pack_cnt_d  = '0;
        pack_last_d = 1'b0;
      end else begin
        // Output slot taken this edge: keep the closed word in the pack.
        pack_full_d = 1'b1;
        pack_last_d = i_en && i_last;
      end
    end

    // A fresh drop beats a clear request.
    ovf_d = drop ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
  end

  // Pack register and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_data_q <= '0;
      pack_cnt_q  <= '0;
      pack_full_q <= 1'b0;
      pack_last_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_full_q <= pack_full_d;
      pack_last_q <= pack_last_d;
      ovf_q       <= ovf_d;
    end
  end

  act_out_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_NUM   (PACK_NUM),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_out_slice (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (load_data),
    .count_i (load_cnt),
    .last_i  (load_last),
    .ready_i (o_ready),
    .valid_o (o_valid),
    .data_o  (o_data_bus),
    .count_o (o_count),
    .last_o  (o_last)
  );

  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_act_packer.sv
// Self-checking bench for act_packer: directed scenarios plus random traffic against a
// queue-based model of the packer.
module tb_act_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned PN = 4;
  localparam int unsigned CW = $clog2(PN + 1);
  localparam int unsigned WW = DW * PN;

  logic          clk;
  logic          rst;
  logic          i_en;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic          i_last;
  logic          i_clr_ovf;
  logic          o_valid;
  logic          o_ready;
  logic [WW-1:0] o_data_bus;
  logic [CW-1:0] o_count;
  logic          o_last;
  logic          o_overflow;

  int checks = 0;
  int errors = 0;

  act_packer #(
    .DATA_WIDTH (DW),
    .PACK_NUM   (PN),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_last     (i_last),
    .i_clr_ovf  (i_clr_ovf),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data_bus (o_data_bus),
    .o_count    (o_count),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: words awaiting delivery (front one is on the output), elements of the open word.
  typedef struct {
    logic [WW-1:0] data;
    int            cnt;
    bit            last;
  } word_t;

  word_t         pend[$];
  logic [DW-1:0] cur[$];
  bit            m_ovf;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cur.delete();
    m_ovf = 1'b0;
  endtask

  // Capacity is one word on the output plus one closed word waiting behind it.
  task automatic model_step(input bit en, input bit valid, input logic [DW-1:0] data,
                            input bit last, input bit ready, input bit clr);
    bit    drop;
    word_t w;
    drop = 1'b0;
    if (pend.size() > 0 && ready) void'(pend.pop_front());
    if (en && valid) begin
      if (pend.size() >= 2) drop = 1'b1;
      else cur.push_back(data);
    end
    if (cur.size() == PN || (en && last && cur.size() > 0)) begin
      w.data = '0;
      for (int i = 0; i < cur.size(); i++) w.data[i*DW +: DW] = cur[i];
      w.cnt  = cur.size();
      w.last = en && last;
      pend.push_back(w);
      cur.delete();
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, WW'(o_valid), WW'(pend.size() > 0));
    if (pend.size() > 0) begin
      chk({tag, "_data"}, o_data_bus, pend[0].data);
      chk({tag, "_count"}, WW'(o_count), WW'(pend[0].cnt));
      chk({tag, "_last"}, WW'(o_last), WW'(pend[0].last));
    end
    chk({tag, "_ovf"}, WW'(o_overflow), WW'(m_ovf));
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input string tag, input bit en, input bit valid,
                      input logic [DW-1:0] data, input bit last, input bit ready,
                      input bit clr);
    i_en       = en;
    i_valid    = valid;
    i_data_bus = data;
    i_last     = last;
    o_ready    = ready;
    i_clr_ovf  = clr;
    @(posedge clk);
    model_step(en, valid, data, last, ready, clr);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, WW'(o_valid), '0);
    chk({tag, "_data"}, o_data_bus, '0);
    chk({tag, "_count"}, WW'(o_count), '0);
    chk({tag, "_last"}, WW'(o_last), '0);
    chk({tag, "_ovf"}, WW'(o_overflow), '0);
  endtask

  initial begin
    rst        = 1'b1;
    i_en       = 1'b0;
    i_valid    = 1'b0;
    i_data_bus = '0;
    i_last     = 1'b0;
    i_clr_ovf  = 1'b0;
    o_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);
    check_outputs("idle");

    // Full word of four elements, latency one cycle.
    for (int i = 1; i <= 4; i++) step("w4", 1, 1, DW'(i), 0, 1, 0);
    chk("w4_const_data", o_data_bus, 64'h0004_0003_0002_0001);
    chk("w4_const_count", WW'(o_count), WW'(4));
    chk("w4_const_last", WW'(o_last), '0);

    // Partial word closed by i_last.
    step("p2a", 1, 1, 16'h00AA, 0, 1, 0);
    step("p2b", 1, 1, 16'h00BB, 1, 1, 0);
    chk("p2_const_data", o_data_bus, 64'h0000_0000_00BB_00AA);
    chk("p2_const_count", WW'(o_count), WW'(2));
    chk("p2_const_last", WW'(o_last), WW'(1));
    step("p2_drain", 0, 0, '0, 0, 1, 0);

    // Stall: two words buffered, ninth element dropped.
    for (int i = 1; i <= 9; i++) step("stall", 1, 1, DW'(16'h0100 + i), 0, 0, 0);
    chk("stall_const_ovf", WW'(o_overflow), WW'(1));
    chk("stall_const_w1", o_data_bus, 64'h0104_0103_0102_0101);
    step("rel1", 0, 0, '0, 0, 1, 0);
    chk("rel1_const_w2", o_data_bus, 64'h0108_0107_0106_0105);
    step("rel2", 0, 0, '0, 0, 1, 0);
    chk("rel2_const_empty", WW'(o_valid), '0);

    // Clear the sticky overflow, then enable-low traffic must be ignored.
    step("clr", 0, 0, '0, 0, 1, 1);
    chk("clr_const_ovf", WW'(o_overflow), '0);
    for (int i = 0; i < 4; i++) step("en0", 0, 1, DW'(16'h0F00 + i), i == 3, 1, 0);
    chk("en0_const_valid", WW'(o_valid), '0);
    chk("en0_const_ovf", WW'(o_overflow), '0);

    // Back-to-back words: valid must not gap.
    for (int i = 0; i < 8; i++) step("b2b", 1, 1, DW'(16'h2000 + i), 0, 1, 0);
    step("b2b_drain", 0, 0, '0, 0, 1, 0);

    // Reset mid-word discards the partial word.
    step("rm1", 1, 1, 16'hDEAD, 0, 1, 0);
    step("rm2", 1, 1, 16'hBEEF, 0, 1, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step("rm_new", 1, 1, DW'(16'h0011 * i), 0, 1, 0);
      chk("rm_new_const_novalid", WW'(o_valid), '0);
    end
    step("rm_new4", 1, 1, 16'h0044, 0, 1, 0);
    chk("rm_const_data", o_data_bus, 64'h0044_0033_0022_0011);
    chk("rm_const_count", WW'(o_count), WW'(4));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, DW'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
